// File: rtl/ml_fc_sequential.sv
// Time-multiplexed fully connected layer: LANES MAC units sweep the output neurons group by group,
// one input element per cycle, with optional ReLU and saturating fixed-point writeback.
`timescale 1ns / 1ps

module ml_fc_sequential #(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned FRAC_BITS  = 16,
   parameter int unsigned IN_LENGTH  = 16,
   parameter int unsigned OUT_LENGTH = 16,
   parameter int unsigned LANES      = 4,
   parameter int unsigned ACT        = 0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic signed [WIDTH-1:0] weights [OUT_LENGTH][IN_LENGTH],
   input  logic signed [WIDTH-1:0] biases  [OUT_LENGTH],
   input  logic signed [WIDTH-1:0] inputs  [IN_LENGTH],
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic signed [WIDTH-1:0] outputs [OUT_LENGTH],
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    sat_flag,
   output logic                    busy
);

   localparam int unsigned G  = OUT_LENGTH / LANES;
   localparam int unsigned KW = (IN_LENGTH > 1) ? $clog2(IN_LENGTH) : 1;
   localparam int unsigned GW = (G > 1) ? $clog2(G) : 1;
   localparam int unsigned OW = (OUT_LENGTH > 1) ? $clog2(OUT_LENGTH) : 1;
   localparam int unsigned AW = 2 * WIDTH + $clog2(IN_LENGTH) + 1;
   // One extra bit so adding the shifted bias can never wrap.
   localparam int unsigned SW = AW + 1;

   localparam logic signed [SW-1:0] SMAX = {{(SW - WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
   localparam logic signed [SW-1:0] SMIN = {{(SW - WIDTH + 1){1'b1}}, {(WIDTH - 1){1'b0}}};

   if (OUT_LENGTH % LANES != 0) begin : g_bad_lanes
      $error("OUT_LENGTH must be a multiple of LANES");
   end

   typedef enum logic [1:0] {StIdle, StMac, StWrite, StDone} state_e;

   state_e                  state_q, state_d;
   logic signed [WIDTH-1:0] x_q     [IN_LENGTH];
   logic signed [AW-1:0]    acc_q   [LANES];
   logic signed [WIDTH-1:0] out_q   [OUT_LENGTH];
   logic [KW-1:0]           k_q;
   logic [GW-1:0]           g_q;
   logic                    sat_q;

   logic [OW-1:0]           row      [LANES];
   logic signed [2*WIDTH-1:0] prod   [LANES];
   logic signed [WIDTH-1:0] lane_res [LANES];
   logic [LANES-1:0]        lane_clamp;
   logic                    last_k, last_g, accept;

   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign busy      = (state_q != StIdle);
   assign sat_flag  = sat_q;
   assign outputs   = out_q;
   assign accept    = in_valid && in_ready;
   assign last_k    = (k_q == KW'(IN_LENGTH - 1));
   assign last_g    = (g_q == GW'(G - 1));

   // Per-lane product and writeback value (bias add, floor shift, ReLU, clamp).
   always_comb begin
      logic signed [SW-1:0] sum;
      logic signed [SW-1:0] shifted;
      for (int l = 0; l < LANES; l++) begin
         row[l]        = OW'(int'(g_q) * int'(LANES) + l);
         prod[l]       = weights[row[l]][k_q] * x_q[k_q];
         sum           = SW'(acc_q[l]) + (SW'(biases[row[l]]) <<< FRAC_BITS);
         shifted       = sum >>> FRAC_BITS;
         lane_clamp[l] = 1'b0;
         lane_res[l]   = shifted[WIDTH-1:0];
         if (ACT == 1 && shifted < 0) begin
            lane_res[l] = '0;
         end else if (shifted > SMAX) begin
            lane_res[l]   = {1'b0, {(WIDTH - 1){1'b1}}};
            lane_clamp[l] = 1'b1;
         end else if (shifted < SMIN) begin
            lane_res[l]   = {1'b1, {(WIDTH - 1){1'b0}}};
            lane_clamp[l] = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (in_valid) state_d = StMac;
         StMac:   if (last_k) state_d = StWrite;
         StWrite: state_d = last_g ? StDone : StMac;
         StDone:  if (out_ready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= StIdle;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q   <= '{default: '0};
         acc_q <= '{default: '0};
         out_q <= '{default: '0};
         k_q   <= '0;
         g_q   <= '0;
         sat_q <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (accept) begin
                  x_q   <= inputs;
                  acc_q <= '{default: '0};
                  k_q   <= '0;
                  g_q   <= '0;
                  sat_q <= 1'b0;
               end
            end
            StMac: begin
               for (int l = 0; l < LANES; l++) acc_q[l] <= acc_q[l] + AW'(prod[l]);
               k_q <= k_q + KW'(1);
            end
            StWrite: begin
               for (int l = 0; l < LANES; l++) out_q[row[l]] <= lane_res[l];
               acc_q <= '{default: '0};
               k_q   <= '0;
               if (|lane_clamp) sat_q <= 1'b1;
               if (!last_g) g_q <= g_q + GW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule
